aes_round_sequencer: RTL

//  Control FSM that runs one AES-128 block through the single-round datapath (ELU) and the key-step unit.

---
 rtl/aes_round_sequencer_pkg.sv | 15 +
 rtl/aes_round_sequencer_rcon.sv | 29 ++
 rtl/aes_round_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_pkg.sv
// Shared widths, round count and FSM encoding for the AES round sequencer.
package aes_round_sequencer_pkg;

  localparam int AES_NR    = 10;   // AES-128 round count
  localparam int AES_W_RND = 4;    // round counter width, holds AES_NR
  localparam int W_DATA    = 128;
  localparam int W_KEY     = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer_rcon.sv
// Round index -> Rcon byte lookup; index 1..10 valid, anything else reads 8'h00.
module aes_round_sequencer_rcon
  import aes_round_sequencer_pkg::*;
#(
  parameter int W_IDX = AES_W_RND
) (
  input  logic [W_IDX-1:0] idx,
  output logic [7:0]       rcon
);

  // Pure LUT; out-of-range indices fall through to zero.
  always_comb begin
    rcon = 8'h00;
    case (int'(idx))
      1:       rcon = 8'h01;
      2:       rcon = 8'h02;
      3:       rcon = 8'h04;
      4:       rcon = 8'h08;
      5:       rcon = 8'h10;
      6:       rcon = 8'h20;
      7:       rcon = 8'h40;
      8:       rcon = 8'h80;
      9:       rcon = 8'h1b;
      10:      rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM that walks one AES-128 block through the external round
// datapath (ELU) and key-step unit. Holds the state, round-key and
// ciphertext registers; all round and key math lives outside.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for a block; in_ready once out of reset
//   S_ROUND | round request to the ELU, waits for rnd_done
//   S_DONE  | ciphertext offered; a new block may be accepted on handoff
module aes_round_sequencer
  import aes_round_sequencer_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int W_RND = AES_W_RND
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_DATA-1:0] plaintext,
  input  logic [W_KEY-1:0]  key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_DATA-1:0] ciphertext,
  output logic              rnd_valid,
  input  logic              rnd_done,
  output logic [W_RND-1:0]  rnd_num,
  output logic              rnd_last,
  output logic [W_DATA-1:0] rnd_state,
  output logic [W_KEY-1:0]  rnd_key,
  input  logic [W_DATA-1:0] rnd_result,
  output logic [7:0]        ks_rcon,
  input  logic [W_KEY-1:0]  ks_key_in,
  output logic              busy
);

  seq_state_e        state_q, state_d;
  logic [W_RND-1:0]  rnd_num_q;
  logic [W_DATA-1:0] state_reg;
  logic [W_KEY-1:0]  key_reg;
  logic [W_DATA-1:0] ct_reg;
  logic              rdy_en;     // keeps in_ready low until the first clock after reset
  logic              accept;
  logic              ld_round;
  logic              ld_final;
  logic              at_last;
  logic [W_RND-1:0]  rcon_idx;

  assign at_last = (rnd_num_q == W_RND'(NR));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state, handshakes and register load strobes.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rnd_valid = 1'b0;
    accept    = 1'b0;
    ld_round  = 1'b0;
    ld_final  = 1'b0;
    rcon_idx  = W_RND'(1);
    case (state_q)
      S_IDLE: begin
        in_ready = rdy_en;
        if (in_valid && rdy_en) begin
          accept  = 1'b1;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        rnd_valid = 1'b1;
        // Key being produced belongs to the next round.
        rcon_idx  = rnd_num_q + W_RND'(1);
        if (rnd_done) begin
          if (at_last) begin
            ld_final = 1'b1;
            state_d  = S_DONE;
          end else begin
            ld_round = 1'b1;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept  = 1'b1;
            state_d = S_ROUND;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Data registers: whitening on accept, round/key update per rnd_done, capture at the end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en    <= 1'b0;
      rnd_num_q <= '0;
      state_reg <= '0;
      key_reg   <= '0;
      ct_reg    <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        state_reg <= plaintext ^ key;
        key_reg   <= ks_key_in;
        rnd_num_q <= W_RND'(1);
      end else if (ld_round) begin
        state_reg <= rnd_result;
        key_reg   <= ks_key_in;
        rnd_num_q <= rnd_num_q + W_RND'(1);
      end else if (ld_final) begin
        ct_reg    <= rnd_result;
        rnd_num_q <= '0;
      end
    end
  end

  aes_round_sequencer_rcon #(.W_IDX(W_RND)) u_rcon (
    .idx  (rcon_idx),
    .rcon (ks_rcon)
  );

  assign rnd_num    = rnd_num_q;
  assign rnd_last   = at_last;
  assign rnd_state  = state_reg;
  assign rnd_key    = key_reg;
  assign ciphertext = ct_reg;
  assign busy       = (state_q != S_IDLE);

endmodule
